pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the five-stage RV32 pipeline: generates per-stage stall/flush and EX-operand forward selects. It adds a multi-cycle MUL/DIV occupancy counter, data-memory wait-state stalling and a saturating stall-cycle counter on top of load-use interlocking and branch/jump flushing. It sits beside the pipeline registers and drives their stall/flush inputs and the EX forwarding muxes.

---
 rtl/riscv_hazard_pkg.sv | 22 ++
 rtl/hazard_fwd_sel.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package riscv_hazard_pkg;

    // EX operand forwarding mux selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MUL/DIV occupancy FSM
    typedef enum logic {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } hz_state_t;

    // Width of the MUL/DIV down-counter: clog2(lat), never below one bit
    function automatic int unsigned muldiv_cnt_width(input int unsigned lat);
        int unsigned w;
        w = $clog2(lat);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one EX operand: MEM result beats WB result beats regfile.
module hazard_fwd_sel
    import riscv_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic              read_en,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [2:0]        reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [2:0]        reg_write_w,
    output logic [1:0]        fwd
);

    logic mem_hit;
    logic wb_hit;

    // x0 is never forwarded; an operand not read by EX never forwards
    always_comb begin
        mem_hit = (|reg_write_m) && (rd_m != '0) && read_en && (rd_m == rs_e);
        wb_hit  = (|reg_write_w) && (rd_w != '0) && read_en && (rd_w == rs_e);
        if (mem_hit) begin
            fwd = FWD_MEM;
        end else if (wb_hit) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_REG;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: memory wait-state stalls,
// multi-cycle MUL/DIV occupancy, load-use interlock, redirect flushes,
// EX operand forwarding and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [1:0]        reg_read_e,
    input  logic              mem_to_reg_e,
    input  logic [2:0]        reg_write_m,
    input  logic [2:0]        reg_write_w,
    input  logic              branch_e,
    input  logic              jalr_e,
    input  logic              jal_d,
    input  logic              muldiv_e,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              stall_w,
    output logic              flush_f,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        fwd1_e,
    output logic [1:0]        fwd2_e,
    output logic              muldiv_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned    CW       = muldiv_cnt_width(MULDIV_LAT);
    localparam bit             MULTI    = (MULDIV_LAT > 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);

    hz_state_t        state_q;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] stall_cycles_q;

    logic dmem_wait;
    logic muldiv_start;
    logic muldiv_stall;
    logic load_use;
    logic redirect;
    logic [1:0] fwd1_raw;
    logic [1:0] fwd2_raw;

    // Hazard conditions derived from the current stage contents and FSM state
    always_comb begin
        dmem_wait    = ~dmem_ready;
        muldiv_start = (state_q == IDLE) && muldiv_e && MULTI;
        muldiv_stall = muldiv_start || ((state_q == MULDIV) && (cnt_q != '0));
        load_use     = mem_to_reg_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        redirect     = branch_e || jalr_e || jal_d;
    end

    // Stall/flush priority: memory wait, then MUL/DIV, then load-use vs redirect.
    // Redirects are held off while D/E are frozen; the redirect inputs persist
    // and the flush lands on the first cycle the pipe moves again.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        stall_w = 1'b0;
        flush_f = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        fwd1_e  = FWD_REG;
        fwd2_e  = FWD_REG;
        if (!rst_n) begin
            flush_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            fwd1_e = fwd1_raw;
            fwd2_e = fwd2_raw;
            if (dmem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (muldiv_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else begin
                if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                if (redirect) begin
                    // Flush wins: the loaded value is no longer needed
                    stall_f = 1'b0;
                    stall_d = 1'b0;
                    flush_d = 1'b1;
                    flush_e = flush_e | branch_e | jalr_e;
                end
            end
        end
    end

    // MUL/DIV occupancy FSM; frozen while data memory is waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (dmem_ready) begin
            case (state_q)
                IDLE: begin
                    if (muldiv_e && MULTI) begin
                        state_q <= MULDIV;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                MULDIV: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (stall_f && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign muldiv_busy  = (state_q == MULDIV);
    assign stall_cycles = stall_cycles_q;

    hazard_fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd1 (
        .rs_e        (rs1_e),
        .read_en     (reg_read_e[1]),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd1_raw)
    );

    hazard_fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd2 (
        .rs_e        (rs2_e),
        .read_en     (reg_read_e[0]),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd2_raw)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed
// expectations per cycle, a monitor pops and compares them on the falling edge.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] reg_read_e;
    logic       mem_to_reg_e;
    logic [2:0] reg_write_m, reg_write_w;
    logic       branch_e, jalr_e, jal_d, muldiv_e, dmem_ready;

    logic        stall_f, stall_d, stall_e, stall_m, stall_w;
    logic        flush_f, flush_d, flush_e, flush_m, flush_w;
    logic [1:0]  fwd1_e, fwd2_e;
    logic        muldiv_busy;
    logic [31:0] stall_cycles;

    logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_stall_w;
    logic        s_flush_f, s_flush_d, s_flush_e, s_flush_m, s_flush_w;
    logic [1:0]  s_fwd1_e, s_fwd2_e;
    logic        s_busy;
    logic [3:0]  s_stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_read_e(reg_read_e), .mem_to_reg_e(mem_to_reg_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .branch_e(branch_e), .jalr_e(jalr_e), .jal_d(jal_d),
        .muldiv_e(muldiv_e), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .stall_w(stall_w),
        .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e),
        .flush_m(flush_m), .flush_w(flush_w),
        .fwd1_e(fwd1_e), .fwd2_e(fwd2_e),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_read_e(reg_read_e), .mem_to_reg_e(mem_to_reg_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .branch_e(branch_e), .jalr_e(jalr_e), .jal_d(jal_d),
        .muldiv_e(muldiv_e), .dmem_ready(dmem_ready),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e),
        .stall_m(s_stall_m), .stall_w(s_stall_w),
        .flush_f(s_flush_f), .flush_d(s_flush_d), .flush_e(s_flush_e),
        .flush_m(s_flush_m), .flush_w(s_flush_w),
        .fwd1_e(s_fwd1_e), .fwd2_e(s_fwd2_e),
        .muldiv_busy(s_busy), .stall_cycles(s_stall_cycles)
    );

    typedef struct {
        string       nm;
        logic [4:0]  st;   // {f,d,e,m,w}
        logic [4:0]  fl;   // {f,d,e,m,w}
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        busy;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_cnt = 0;

    task automatic chk(input string nm, input string what, input logic [31:0] act,
                       input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s/%s actual=%0h expected=%0h", nm, what, act, expv);
        end
    endtask

    // Monitor: one expectation per cycle, sampled away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk(e.nm, "stall", 32'({stall_f, stall_d, stall_e, stall_m, stall_w}), 32'(e.st));
                chk(e.nm, "flush", 32'({flush_f, flush_d, flush_e, flush_m, flush_w}), 32'(e.fl));
                chk(e.nm, "fwd1", 32'(fwd1_e), 32'(e.f1));
                chk(e.nm, "fwd2", 32'(fwd2_e), 32'(e.f2));
                chk(e.nm, "busy", 32'(muldiv_busy), 32'(e.busy));
                chk(e.nm, "cnt", stall_cycles, e.cnt);
                chk(e.nm, "sat_cnt", 32'(s_stall_cycles), 32'(e.cnt4));
                chk(e.nm, "sat_ctl",
                    32'({s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_stall_w,
                         s_flush_f, s_flush_d, s_flush_e, s_flush_m, s_flush_w,
                         s_fwd1_e, s_fwd2_e, s_busy}),
                    32'({e.st, e.fl, e.f1, e.f2, e.busy}));
            end
        end
    end

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0;
        reg_read_e = 2'b00; mem_to_reg_e = 0;
        reg_write_m = 3'b000; reg_write_w = 3'b000;
        branch_e = 0; jalr_e = 0; jal_d = 0; muldiv_e = 0;
        dmem_ready = 1;
    endtask

    // Push the expectation for the current inputs, then advance one cycle
    task automatic cyc(input string nm, input logic [4:0] st, input logic [4:0] fl,
                       input logic [1:0] f1, input logic [1:0] f2, input logic busy);
        exp_t e;
        if (!rst_n) exp_cnt = 0;
        e.nm   = nm;
        e.st   = st;
        e.fl   = fl;
        e.f1   = f1;
        e.f2   = f2;
        e.busy = busy;
        e.cnt  = 32'(exp_cnt);
        e.cnt4 = (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt);
        sbq.push_back(e);
        if (rst_n && st[4]) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        cyc("reset0", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0);
        cyc("reset1", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        cyc("idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);

        // Load-use interlock
        mem_to_reg_e = 1; rd_e = 5; rs1_d = 5;
        cyc("ld_use_rs1", 5'b11000, 5'b00100, 2'b00, 2'b00, 1'b0);
        rd_e = 0; rs1_d = 0;
        cyc("ld_x0", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);
        rd_e = 9; rs1_d = 3; rs2_d = 9;
        cyc("ld_use_rs2", 5'b11000, 5'b00100, 2'b00, 2'b00, 1'b0);
        branch_e = 1;
        cyc("ld_use_br", 5'b00000, 5'b01100, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        jal_d = 1;
        cyc("jal", 5'b00000, 5'b01000, 2'b00, 2'b00, 1'b0);
        jal_d = 0; jalr_e = 1;
        cyc("jalr", 5'b00000, 5'b01100, 2'b00, 2'b00, 1'b0);
        clear_inputs();

        // MUL/DIV occupancy, LAT=4
        muldiv_e = 1;
        cyc("md_t0", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b0);
        cyc("md_t1", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1);
        cyc("md_t2", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1);
        cyc("md_t3", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b1);
        muldiv_e = 0;
        cyc("md_t4", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);

        // Memory wait masks a pending branch flush
        dmem_ready = 0; branch_e = 1;
        cyc("dw_br0", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b0);
        cyc("dw_br1", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b0);
        cyc("dw_br2", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b0);
        dmem_ready = 1;
        cyc("dw_br_rdy", 5'b00000, 5'b01100, 2'b00, 2'b00, 1'b0);
        clear_inputs();

        // Memory wait during MUL/DIV stretches it by exactly one cycle
        muldiv_e = 1;
        cyc("mdw_t0", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b0);
        dmem_ready = 0;
        cyc("mdw_wait", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b1);
        dmem_ready = 1;
        cyc("mdw_t1", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1);
        cyc("mdw_t2", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b1);
        cyc("mdw_t3", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b1);
        muldiv_e = 0;
        cyc("mdw_t4", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);

        // Forwarding
        rd_m = 7; rd_w = 7; rs1_e = 7; reg_read_e = 2'b10;
        reg_write_m = 3'b001; reg_write_w = 3'b001;
        cyc("fwd_mem", 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b0);
        rd_m = 0;
        cyc("fwd_wb", 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0);
        reg_read_e = 2'b00;
        cyc("fwd_noread", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);
        rd_m = 7; rs2_e = 7; reg_read_e = 2'b01;
        reg_write_m = 3'b000; reg_write_w = 3'b100;
        cyc("fwd2_wb", 5'b00000, 5'b00000, 2'b00, 2'b01, 1'b0);
        reg_write_m = 3'b010; reg_read_e = 2'b11;
        cyc("fwd_both_mem", 5'b00000, 5'b00000, 2'b10, 2'b10, 1'b0);
        clear_inputs();

        // Reset asserted right after MUL/DIV entry (counter loaded with 2)
        muldiv_e = 1;
        cyc("rm_t0", 5'b11100, 5'b00010, 2'b00, 2'b00, 1'b0);
        rst_n = 0; muldiv_e = 0;
        cyc("rm_rst0", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0);
        cyc("rm_rst1", 5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0);
        rst_n = 1;
        cyc("rm_idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);

        // 20 stall cycles: 4-bit counter saturates at 15
        dmem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("sat", 5'b11110, 5'b00001, 2'b00, 2'b00, 1'b0);
        end
        dmem_ready = 1;
        cyc("sat_end", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);
        cyc("sat_hold", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
